// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor under a
// start/ready/done handshake and returns quotient and remainder.
// Optional macro SEQ_DIVIDER_ERR_CHECK_EN: when defined, a zero divisor or
// an overflowing dividend is flagged at accept time and answered with
// err=1 after a single cycle; when undefined, err is tied low.

module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    // Partial remainder: its top bit is implicit because after every
    // iteration of an exact division it stays below the divisor.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
    logic             err_q, err_d;
`endif

    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] r_sub;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // Next-state logic: handshake, one restoring iteration, result capture.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
        err_d   = err_q;
`endif

        r_shift = {r_q, q_q[WIDTH-1]};
        fits    = (r_shift >= {1'b0, d_q});
        r_sub   = r_shift[WIDTH-1:0] - d_q;
        r_next  = fits ? r_sub : r_shift[WIDTH-1:0];
        q_next  = {q_q[WIDTH-2:0], fits};

        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = dividend[2*WIDTH-1:WIDTH];
                    q_d     = dividend[WIDTH-1:0];
                    d_d     = divisor;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
                    err_d   = 1'b0;
                    if ((divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end
`endif
                end
            end
            RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quo_d   = q_next;
                    rem_d   = r_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=8).
// Expected results come from plain integer division at issue time;
// a monitor pops them whenever done pulses. Honours SEQ_DIVIDER_ERR_CHECK_EN.

module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  dividend = '0;
    logic [7:0]   divisor = '0;
    logic         ready;
    logic         done;
    logic [7:0]   quotient;
    logic [7:0]   remainder;
    logic         err;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        bit         chk;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] hold_q = '0;
    logic [7:0] hold_r = '0;
    bit         hold_valid = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time-stamp accepts and done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Reference model: plain integer division plus the error rules.
    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs, input int acc_cyc);
        exp_t e;
        int   num = int'(dvd);
        int   den = int'(dvs);
        int   hi  = num / 256;
        e.q   = '0;
        e.r   = '0;
        e.e   = 1'b0;
        e.chk = 1'b0;
        e.due = acc_cyc + 1 + W;
        if (den != 0 && hi < den) begin
            e.q   = 8'(num / den);
            e.r   = 8'(num % den);
            e.chk = 1'b1;
        end
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
        if (den == 0 || hi >= den) begin
            e.q   = 8'hFF;
            e.r   = 8'h00;
            e.e   = 1'b1;
            e.chk = 1'b1;
            e.due = acc_cyc + 1;
        end
`endif
        return e;
    endfunction

    // Issue one request: called at a falling edge; waits (bounded) for ready.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got ready=0 for %0d cycles, expected ready=1", n);
            return;
        end
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back(model(dvd, dvs, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic randValid(output logic [15:0] dvd, output logic [7:0] dvs);
        int d  = $urandom_range(1, 255);
        int hi = $urandom_range(0, d - 1);
        int lo = $urandom_range(0, 255);
        dvs = 8'(d);
        dvd = 16'(hi * 256 + lo);
    endtask

    // Monitor: samples 1 time unit after each rising edge and scores outputs.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            checkOutput("reset_ready", int'(ready), 1);
            checkOutput("reset_done", int'(done), 0);
            checkOutput("reset_quotient", int'(quotient), 0);
            checkOutput("reset_remainder", int'(remainder), 0);
            checkOutput("reset_err", int'(err), 0);
            hold_q     = '0;
            hold_r     = '0;
            hold_valid = 1'b1;
        end else if (done) begin
            checkOutput("ready_during_done", int'(ready), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending request", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_cycle", cyc, mon_e.due);
                checkOutput("err", int'(err), int'(mon_e.e));
                if (mon_e.chk) begin
                    checkOutput("quotient", int'(quotient), int'(mon_e.q));
                    checkOutput("remainder", int'(remainder), int'(mon_e.r));
                    hold_q     = mon_e.q;
                    hold_r     = mon_e.r;
                    hold_valid = 1'b1;
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end else if (hold_valid) begin
            checkOutput("quotient_hold", int'(quotient), int'(hold_q));
            checkOutput("remainder_hold", int'(remainder), int'(hold_r));
        end
    end

    // Main sequence: reset, directed cases, back-to-back start, reset abort, random.
    initial begin
        logic [15:0] dvd;
        logic [7:0]  dvs;
        int          prev;

        $display("[TB] seq_divider bench start");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'd1000, 8'd7);
        applyStimulus(16'd65025, 8'd255);
        applyStimulus(16'd5, 8'd9);
`ifdef SEQ_DIVIDER_ERR_CHECK_EN
        applyStimulus(16'd1234, 8'd0);
        applyStimulus(16'd65535, 8'd255);
`endif
        drain();

        prev  = -1;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            randValid(dvd, dvs);
            dividend = dvd;
            divisor  = dvs;
            if (ready) begin
                sb.push_back(model(dvd, dvs, cyc));
                if (prev >= 0) checkOutput("accept_spacing", cyc - prev, W + 2);
                prev = cyc;
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        applyStimulus(16'd1000, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(16'd200, 8'd3);
        drain();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                dvd = 16'($urandom);
                dvs = 8'($urandom_range(0, 255));
            end else begin
                randValid(dvd, dvs);
            end
            applyStimulus(dvd, dvs);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
